// File: rtl/adder_seq_pkg.sv
// Shared definitions for the full_adder AXI4-Lite sequencer: FSM encoding,
// peripheral register map and AXI response codes.
package adder_seq_pkg;

    // Sequencer FSM encoding (explicit 3-bit values for legacy tools)
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RA   = 3'd3,
        RD   = 3'd4,
        RSP  = 3'd5
    } seq_state_e;

    // full_adder register byte offsets
    localparam logic [31:0] REG_A   = 32'h0000_0000;
    localparam logic [31:0] REG_B   = 32'h0000_0004;
    localparam logic [31:0] REG_CIN = 32'h0000_0008;
    localparam logic [31:0] REG_RES = 32'h0000_000C;

    // AXI response code for a successful transfer
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Byte offset of the operand register written in step idx (0..2)
    function automatic logic [31:0] reg_off(input logic [1:0] idx);
        logic [31:0] off;
        case (idx)
            2'd0:    off = REG_A;
            2'd1:    off = REG_B;
            default: off = REG_CIN;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/adder_axil_sequencer.sv
// AXI4-Lite master that runs one full-adder operation on the full_adder
// peripheral: writes A, B and carry-in to registers 0..2, reads register 3
// and returns it on a valid/ready response port. Every output is a flop.
module adder_axil_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_BASE_ADDR        = 0,
    parameter int unsigned C_CNT_WIDTH        = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    // operand request
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     req_a,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     req_b,
    input  logic                              req_cin,
    // result response
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data,
    output logic                              rsp_err,
    output logic [C_CNT_WIDTH-1:0]            op_count,
    // AXI4-Lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    // AXI4-Lite write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    // AXI4-Lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    // AXI4-Lite read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned CW = C_CNT_WIDTH;

    // Peripheral address of a register offset, truncated to the bus width
    function automatic logic [AW-1:0] reg_addr(input logic [31:0] off);
        logic [31:0] sum;
        sum = 32'(C_BASE_ADDR) + off;
        return sum[AW-1:0];
    endfunction

    // Write data for step idx: A, then B, then the zero-extended carry-in
    function automatic logic [DW-1:0] wdata_sel(input logic [1:0]    idx,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b,
                                                input logic          cin);
        logic [DW-1:0] d;
        case (idx)
            2'd0:    d = a;
            2'd1:    d = b;
            default: d = {{(DW-1){1'b0}}, cin};
        endcase
        return d;
    endfunction

    seq_state_e      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            cin_q, cin_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            req_ready_q, req_ready_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic            awvalid_q, awvalid_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic [CW-1:0]   op_count_q, op_count_d;

    logic            aw_hs_s;
    logic            w_hs_s;
    logic [1:0]      idx_nxt_s;

    assign aw_hs_s   = awvalid_q & m_axi_awready;
    assign w_hs_s    = wvalid_q & m_axi_wready;
    assign idx_nxt_s = idx_q + 2'd1;

    // Next-state and next-output logic for the sequencer FSM
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        req_ready_d = 1'b0;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_d       = req_a;
                    b_d       = req_b;
                    cin_d     = req_cin;
                    idx_d     = 2'd0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = reg_addr(reg_off(2'd0));
                    wdata_d   = req_a;
                    state_d   = WR;
                end else begin
                    // idle: advertise readiness (also raises it after reset)
                    req_ready_d = 1'b1;
                end
            end

            WR: begin
                // AW and W complete independently; each valid drops on its own handshake
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (w_hs_s) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    w_done_d = w_done_q;
                end
                if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
                    bready_d = 1'b1;
                    state_d  = WB;
                end else begin
                    state_d = WR;
                end
            end

            WB: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_d = 1'b0;
                    if (m_axi_bresp != AXI_RESP_OKAY) begin
                        // failed write: skip the rest and report the error
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = {DW{1'b0}};
                        state_d     = RSP;
                    end else if (idx_q < 2'd2) begin
                        idx_d     = idx_nxt_s;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = reg_addr(reg_off(idx_nxt_s));
                        wdata_d   = wdata_sel(idx_nxt_s, a_q, b_q, cin_q);
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr(REG_RES);
                        state_d   = RA;
                    end
                end else begin
                    state_d = WB;
                end
            end

            RA: begin
                if (m_axi_arready && arvalid_q) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD;
                end else begin
                    state_d = RA;
                end
            end

            RD: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = m_axi_rdata;
                    rsp_err_d   = (m_axi_rresp != AXI_RESP_OKAY);
                    state_d     = RSP;
                end else begin
                    state_d = RD;
                end
            end

            RSP: begin
                if (rsp_ready && rsp_valid_q) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                    if (!rsp_err_q) begin
                        op_count_d = op_count_q + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        op_count_d = op_count_q;
                    end
                end else begin
                    state_d = RSP;
                end
            end

            default: begin
                // illegal encoding: drop every handshake and return to idle
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            a_q         <= {DW{1'b0}};
            b_q         <= {DW{1'b0}};
            cin_q       <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b0;
            awaddr_q    <= {AW{1'b0}};
            awvalid_q   <= 1'b0;
            wdata_q     <= {DW{1'b0}};
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= {AW{1'b0}};
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DW{1'b0}};
            rsp_err_q   <= 1'b0;
            op_count_q  <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            req_ready_q <= req_ready_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign op_count      = op_count_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = {(DW/8){1'b1}};
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
